// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and state encodings for the instruction fetch unit.
package if_fetch_pkg;
   localparam logic Enable = 1'b1;
   localparam logic Disable = 1'b0;
   localparam int AddrBus = 32;
   localparam int InstBus = 32;
   localparam int ByteBus = 8;
   localparam logic [31:0] ZeroWord = 32'h0;
   localparam logic [2:0] BytesPerInst = 3'd4;
   localparam logic [1:0] IF_IDLE = 2'd0;
   localparam logic [1:0] IF_FETCH = 2'd1;
   localparam logic [1:0] IF_OUT = 2'd2;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch with valid/stall handoff to decode.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int ADDR_W = AddrBus,
   parameter int INST_W = InstBus
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic               jump_enable,
   input  logic               mem_gnt,
   input  logic [ByteBus-1:0] mem_din,
   output logic               mem_rd,
   output logic [ADDR_W-1:0]  mem_a,
   input  logic               id_stall,
   output logic               inst_valid,
   output logic [INST_W-1:0]  inst_o,
   output logic [ADDR_W-1:0]  inst_pc_o,
   output logic               stall_req
);
   logic [1:0] state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [2:0] issue_cnt, recv_cnt, recv_next;
   logic pending, accept;
   always_comb begin
      mem_rd = rdy && state == IF_FETCH && issue_cnt < BytesPerInst;
      mem_a = mem_rd ? fetch_pc + ADDR_W'(issue_cnt) : ADDR_W'(ZeroWord);
      accept = mem_rd && mem_gnt;
      recv_next = recv_cnt + {2'b00, pending};
      inst_valid = state == IF_OUT;
      stall_req = !(inst_valid && !id_stall);
   end
   // a byte granted last cycle lands even while frozen, so capture ignores rdy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IF_IDLE;
         fetch_pc <= '0;
         issue_cnt <= '0;
         recv_cnt <= '0;
         pending <= Disable;
         inst_o <= '0;
         inst_pc_o <= '0;
      end else if (jump_enable) begin
         state <= IF_IDLE;
         issue_cnt <= '0;
         recv_cnt <= '0;
         pending <= Disable;
      end else begin
         pending <= accept;
         if (pending) begin
            inst_o[{recv_cnt[1:0], 3'b000} +: ByteBus] <= mem_din;
            recv_cnt <= recv_next;
         end
         if (rdy) begin
            if (state == IF_IDLE) begin
               fetch_pc <= pc_i;
               issue_cnt <= '0;
               recv_cnt <= '0;
               state <= IF_FETCH;
            end else if (state == IF_FETCH) begin
               if (accept) issue_cnt <= issue_cnt + 3'd1;
               if (recv_next == BytesPerInst) begin
                  inst_pc_o <= fetch_pc;
                  state <= IF_OUT;
               end
            end else if (state != IF_OUT || !id_stall) begin
               state <= IF_IDLE;
            end
         end
      end
   end
endmodule
